// File: rtl/sev_seg_mux_if.sv
// Display-side bundle for sev_seg_mux: digit data in, registered digit select,
// active-low segments and frame marker out.
interface sev_seg_mux_if #(
    parameter int NUM_DIGITS = 2
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [6:0]              seg;
    logic                    frame_start;

    // master: the multiplexer driving the display; slave: the host supplying digits
    modport master (
        input  digits, digit_en,
        output digit_sel, seg, frame_start
    );
    modport slave (
        output digits, digit_en,
        input  digit_sel, seg, frame_start
    );
endinterface

// File: rtl/sev_seg_mux.sv
// Time-multiplexed 7-segment driver: DISP dwell per digit, optional all-off BLANK gap,
// per-frame input snapshot. Define SEV_SEG_LZB_EN to enable leading-zero blanking.
module sev_seg_mux #(
    parameter int NUM_DIGITS   = 2,
    parameter int REFRESH_DIV  = 2500,
    parameter int BLANK_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    sev_seg_mux_if.master bus
);
    typedef enum logic {DISP, BLANK} state_e;

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    run_q, run_d;
    logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [6:0]              seg_q, seg_d;
    logic                    fs_q, fs_d;
    logic                    enter_frame;
    logic                    advance;
    logic [NUM_DIGITS-1:0]   eff_en;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        decode = 7'h7F;
        unique case (nib)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            4'hF: decode = 7'h0E;
        endcase
    endfunction

    // run_q low means "pending entry": the first edge out of reset starts frame 0.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        run_d       = 1'b1;
        snap_dig_d  = snap_dig_q;
        snap_en_d   = snap_en_q;
        enter_frame = 1'b0;
        advance     = 1'b0;

        if (!run_q) begin
            state_d     = DISP;
            cnt_d       = '0;
            idx_d       = '0;
            enter_frame = 1'b1;
        end else begin
            unique case (state_q)
                DISP: begin
                    if (cnt_q == DISP_LAST) begin
                        cnt_d = '0;
                        if (HAS_BLANK) state_d = BLANK;
                        else           advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = DISP;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
            if (advance) begin
                enter_frame = (idx_q == IDX_LAST);
                idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
        end

        if (enter_frame) begin
            snap_dig_d = bus.digits;
            snap_en_d  = bus.digit_en;
        end
    end

`ifdef SEV_SEG_LZB_EN
    // A digit above 0 goes dark when it and every more-significant nibble are zero.
    logic zero_run;
    always_comb begin
        zero_run = 1'b1;
        eff_en   = snap_en_d;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (snap_dig_d[4*i +: 4] == 4'h0);
            if (zero_run) eff_en[i] = 1'b0;
        end
    end
`else
    assign eff_en = snap_en_d;
`endif

    // Outputs are computed from next state so they are valid the cycle state changes.
    always_comb begin
        sel_d = '0;
        seg_d = 7'h7F;
        fs_d  = enter_frame;
        if (state_d == DISP) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == IDX_W'(i) && eff_en[i]) begin
                    sel_d[i] = 1'b1;
                    seg_d    = decode(snap_dig_d[4*i +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= DISP;
            cnt_q      <= '0;
            idx_q      <= '0;
            run_q      <= 1'b0;
            snap_dig_q <= '0;
            snap_en_q  <= '0;
            sel_q      <= '0;
            seg_q      <= 7'h7F;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            run_q      <= run_d;
            snap_dig_q <= snap_dig_d;
            snap_en_q  <= snap_en_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            fs_q       <= fs_d;
        end
    end

    assign bus.digit_sel   = sel_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_sev_seg_mux.sv
// Bench for sev_seg_mux: a 2-digit/4-dwell/1-blank instance and a 1-digit/no-blank
// instance share a reset; a frame-timeline model feeds a scoreboard queue.
module tb_sev_seg_mux;
    localparam int A_N = 2, A_R = 4, A_B = 1;
    localparam int B_R = 4;
    localparam int A_SLOT = A_R + A_B;
    localparam int A_P    = A_N * A_SLOT;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    sev_seg_mux_if #(.NUM_DIGITS(2)) bus_a ();
    sev_seg_mux_if #(.NUM_DIGITS(1)) bus_b ();

    sev_seg_mux #(.NUM_DIGITS(A_N), .REFRESH_DIV(A_R), .BLANK_CYCLES(A_B)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );
    sev_seg_mux #(.NUM_DIGITS(1), .REFRESH_DIV(B_R), .BLANK_CYCLES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    int         t = 0;
    logic [7:0] snap_a_d = '0;
    logic [1:0] snap_a_e = '0;
    logic [3:0] snap_b_d = '0;
    logic       snap_b_e = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [111:0] tbl;
        tbl = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
               7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        return tbl[int'(n)*7 +: 7];
    endfunction

    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back($sformatf("t%0d %s", t, tag));
        exp_q.push_back(exp);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string       tg;
        logic [31:0] ex;
        tg = tag_q.pop_front();
        ex = exp_q.pop_front();
        check(tg, obs, ex);
    endtask

    // One clock: drive at negedge, predict what the edge will produce, compare after it.
    task automatic step(input logic rst, input logic [7:0] da, input logic [1:0] ea,
                        input logic [3:0] db, input logic eb);
        int         pos, slot;
        logic       on;
        logic [3:0] nib;
        @(negedge clk);
        reset          = rst;
        bus_a.digits   = da;
        bus_a.digit_en = ea;
        bus_b.digits   = db;
        bus_b.digit_en = eb;

        if (rst) begin
            t = 0;
            push("a_sel", 32'h0);  push("a_seg", 32'h7F); push("a_fs", 32'h0);
            push("b_sel", 32'h0);  push("b_seg", 32'h7F); push("b_fs", 32'h0);
        end else begin
            t++;
            pos = (t - 1) % A_P;
            if (pos == 0) begin
                snap_a_d = da;
                snap_a_e = ea;
            end
            slot = pos / A_SLOT;
            nib  = 4'((snap_a_d >> (4 * slot)) & 8'h0F);
            on   = ((pos % A_SLOT) < A_R) && snap_a_e[slot];
`ifdef SEV_SEG_LZB_EN
            if (slot == 1 && snap_a_d[7:4] == 4'h0) on = 1'b0;
`endif
            push("a_sel", on ? 32'(1 << slot) : 32'h0);
            push("a_seg", on ? 32'(seg_of(nib)) : 32'h7F);
            push("a_fs",  32'(pos == 0));

            pos = (t - 1) % B_R;
            if (pos == 0) begin
                snap_b_d = db;
                snap_b_e = eb;
            end
            push("b_sel", 32'(snap_b_e));
            push("b_seg", snap_b_e ? 32'(seg_of(snap_b_d)) : 32'h7F);
            push("b_fs",  32'(pos == 0));
        end

        @(posedge clk);
        #1;
        pop_check(32'(bus_a.digit_sel));
        pop_check(32'(bus_a.seg));
        pop_check(32'(bus_a.frame_start));
        pop_check(32'(bus_b.digit_sel));
        pop_check(32'(bus_b.seg));
        pop_check(32'(bus_b.frame_start));
    endtask

    initial begin
        reset          = 1'b1;
        bus_a.digits   = 8'h3A;
        bus_a.digit_en = 2'b11;
        bus_b.digits   = 4'hF;
        bus_b.digit_en = 1'b1;

        repeat (3) step(1'b1, 8'h3A, 2'b11, 4'hF, 1'b1);

        // Basic frame, then an input change mid-frame that must wait for the next frame
        for (int c = 1; c <= 20; c++)
            step(1'b0, (c >= 3) ? 8'h55 : 8'h3A, 2'b11, (c >= 3) ? 4'h6 : 4'hF, 1'b1);

        // Leading zero on digit 1
        for (int c = 0; c < 20; c++) step(1'b0, 8'h05, 2'b11, 4'h0, 1'b1);

        // Digit 0 disabled, slot timing unchanged
        for (int c = 0; c < 20; c++) step(1'b0, 8'h9C, 2'b10, 4'hB, 1'b0);

        // Reset pulse in the middle of digit 1's dwell
        step(1'b1, 8'h3A, 2'b11, 4'hF, 1'b1);
        for (int c = 0; c < 6; c++) step(1'b0, 8'h3A, 2'b11, 4'hF, 1'b1);
        step(1'b1, 8'h3A, 2'b11, 4'hF, 1'b1);
        for (int c = 0; c < 15; c++) step(1'b0, 8'hD2, 2'b11, 4'hE, 1'b1);

        // Random inputs every cycle with occasional resets
        for (int c = 0; c < 120; c++)
            step(($urandom_range(0, 39) == 0), 8'($urandom), 2'($urandom),
                 4'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sev_seg_mux.md
SEV_SEG_MUX -- requirements
Module: sev_seg_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 2, number of multiplexed digits (legal 1..8).
REQ-002 Parameter REFRESH_DIV, default 2500, display dwell per digit in clk cycles (legal >=1).
REQ-003 Parameter BLANK_CYCLES, default 16, all-off gap after each dwell in clk cycles (legal >=0).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 digits  input  4*NUM_DIGITS  hex nibbles; digit i at bits [4i+3:4i]; digit 0 least significant.
REQ-007 digit_en  input  NUM_DIGITS  per-digit enable; 0 = digit dark.
REQ-008 digit_sel  output  NUM_DIGITS  registered one-hot active-high digit select.
REQ-009 seg  output  7  registered active-low segments {g,f,e,d,c,b,a}.
REQ-010 frame_start  output  1  registered one-cycle pulse marking start of each frame.

Function
REQ-011 FSM states SHALL be DISP and BLANK; a dwell counter and digit index idx (0..NUM_DIGITS-1) SHALL accompany them.
REQ-012 DISP SHALL last exactly REFRESH_DIV cycles, then BLANK exactly BLANK_CYCLES cycles; BLANK_CYCLES=0 SHALL skip BLANK entirely.
REQ-013 idx SHALL advance on leaving BLANK (or DISP if BLANK skipped); idx NUM_DIGITS-1 SHALL wrap to 0.
REQ-014 On each edge entering DISP with idx=0, digits and digit_en SHALL be snapshotted; display SHALL use only snapshot values for the whole frame (no tearing).
REQ-015 frame_start SHALL be 1 exactly in the first DISP cycle of idx 0, else 0.
REQ-016 In DISP: digit_sel = one-hot(idx) if snapshot digit_en[idx]=1, else all 0; seg = decode(snapshot nibble idx), or 7'h7F if disabled.
REQ-017 In BLANK: digit_sel all 0, seg 7'h7F.
REQ-018 Decode (hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-019 Disabled digits SHALL still occupy their full time slot (constant duty per digit).
REQ-020 NUM_DIGITS=1: idx stays 0, snapshot and frame_start every DISP entry, BLANK still inserted.
REQ-021 At most one bit of digit_sel SHALL be 1 in any cycle; digit_sel SHALL never change from one nonzero value to another without an intervening all-0 cycle when BLANK_CYCLES>=1.

Reset
REQ-022 While reset=1: digit_sel=0, seg=7'h7F, frame_start=0, idx=0, counter=0, snapshot=0, state=DISP (pending entry).
REQ-023 First edge with reset=0 SHALL enter DISP idx 0, take the snapshot and assert frame_start; outputs reflect it after that edge.
REQ-024 Reset asserted mid-dwell or mid-blank SHALL abort immediately to REQ-022 values on the next edge.

Configuration
REQ-025 Macro SEV_SEG_LZB_EN: when defined, leading-zero blanking SHALL apply: digit i>0 treated as disabled if snapshot nibbles i..NUM_DIGITS-1 are all zero; digit 0 never blanked by this rule.
REQ-026 Without SEV_SEG_LZB_EN, every enabled digit SHALL be displayed including leading zeros; no LZB logic present.

Verification (NUM_DIGITS=2, REFRESH_DIV=4, BLANK_CYCLES=1 unless noted)
REQ-027 Release reset, digits=8'h3A, en=2'b11 -> cycles 1-4 sel=01 seg=08, cycle 5 sel=00 seg=7F, 6-9 sel=10 seg=30, 10 blank, frame_start at cycles 1 and 11.
REQ-028 Change digits 8'h3A->8'h55 at cycle 3 -> digit1 still shows 30 in cycles 6-9; 12 appears from frame at cycle 11.
REQ-029 digits=8'h05, en=2'b11, SEV_SEG_LZB_EN defined -> digit1 slot sel=00 seg=7F; undefined -> sel=10 seg=40.
REQ-030 en=2'b10 -> digit0 slot sel=00 seg=7F for 4 cycles; frame period stays 10 cycles.
REQ-031 Assert reset at cycle 7 for 1 cycle -> next edge outputs sel=00 seg=7F; on release digit0 restarts with frame_start=1.
REQ-032 BLANK_CYCLES=0, NUM_DIGITS=1, digits=4'hF -> sel=1 seg=0E continuously, frame_start every 4 cycles.
